// File: rtl/frame_buf_pkg.sv
// Shared constants, FSM encodings and address helpers for the multi-channel
// frame buffer address controller.
package frame_buf_pkg;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_FILL = 1'b1;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_READ = 1'b1;

  function automatic int clog2(input int value);
    int result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Elaboration-time only; the datapath steps between slots with an adder.
  function automatic logic [63:0] slot_base(input int base, input int ch, input int slot,
                                            input int num_frames, input int buf_size);
    return 64'(base) + 64'(ch * num_frames + slot) * 64'(buf_size);
  endfunction

endpackage

// File: rtl/frame_buf_chan.sv
// One channel of the frame buffer: writer and reader FSMs, slot rings,
// offsets and the complete-frame counter.
module frame_buf_chan
  import frame_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = 29,
  parameter int BASE_ADDR  = 2,
  parameter int BUF_SIZE   = 230400,
  parameter int NUM_FRAMES = 3,
  parameter int RD_REPEAT  = 0,
  parameter int CH         = 0,
  parameter int CW         = clog2(NUM_FRAMES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_in,
  input  logic                  rd_en_in,
  input  logic                  wr_rdy,
  input  logic                  rd_rdy,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  wr_full,
  output logic [CW-1:0]         frm_cnt
);

  localparam int OW = (clog2(BUF_SIZE) > 0) ? clog2(BUF_SIZE) : 1;
  localparam int SW = (clog2(NUM_FRAMES) > 0) ? clog2(NUM_FRAMES) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE0 =
    ADDR_WIDTH'(slot_base(BASE_ADDR, CH, 0, NUM_FRAMES, BUF_SIZE));
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(BUF_SIZE);
  localparam logic [OW-1:0]         LAST_OFF  = OW'(BUF_SIZE - 1);
  localparam logic [SW-1:0]         LAST_SLOT = SW'(NUM_FRAMES - 1);

  logic [0:0]            wr_state_reg, rd_state_reg;
  logic                  wr_en_reg, rd_en_reg;
  logic [OW-1:0]         wr_off_reg, rd_off_reg;
  logic [SW-1:0]         wr_slot_reg, rd_slot_reg;
  logic [ADDR_WIDTH-1:0] wr_base_reg, rd_base_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg, rd_addr_reg;
  logic [CW-1:0]         frm_cnt_reg;
  logic                  wr_full_reg;

  logic                  wr_beat, wr_done, rd_beat, rd_last, rd_release;
  logic [ADDR_WIDTH-1:0] wr_base_next, rd_base_next;
  logic [CW:0]           frm_avail;
  logic [CW-1:0]         frm_cnt_next;

  always_comb begin
    wr_beat      = (wr_en_reg == ASSERT_L) && (wr_rdy == ASSERT_H);
    wr_done      = wr_beat && (wr_off_reg == LAST_OFF);
    rd_beat      = (rd_en_reg == ASSERT_L) && (rd_rdy == ASSERT_H);
    rd_last      = rd_beat && (rd_off_reg == LAST_OFF);
    // A frame finishing on the writer this cycle counts as newer data for the repeat decision.
    frm_avail    = {1'b0, frm_cnt_reg} + {{CW{1'b0}}, wr_done};
    rd_release   = rd_last && ((RD_REPEAT == 0) || (frm_avail >= (CW + 1)'(2)));
    frm_cnt_next = frm_cnt_reg + CW'(wr_done) - CW'(rd_release);
    wr_base_next = (wr_slot_reg == LAST_SLOT) ? BASE0 : wr_base_reg + STEP;
    rd_base_next = (rd_slot_reg == LAST_SLOT) ? BASE0 : rd_base_reg + STEP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_reg <= WR_IDLE;
      wr_en_reg    <= DEASSERT_L;
      wr_off_reg   <= '0;
      wr_slot_reg  <= '0;
      wr_base_reg  <= BASE0;
      wr_addr_reg  <= BASE0;
    end else begin
      case (wr_state_reg)
        WR_IDLE: begin
          if ((wr_en_in == ASSERT_L) && (frm_cnt_reg < CW'(NUM_FRAMES))) begin
            wr_state_reg <= WR_FILL;
            wr_en_reg    <= ASSERT_L;
          end
        end
        default: begin
          if (wr_done) begin
            wr_state_reg <= WR_IDLE;
            wr_en_reg    <= DEASSERT_L;
            wr_off_reg   <= '0;
            wr_slot_reg  <= (wr_slot_reg == LAST_SLOT) ? '0 : wr_slot_reg + SW'(1);
            wr_base_reg  <= wr_base_next;
            wr_addr_reg  <= wr_base_next;
          end else begin
            wr_en_reg <= wr_en_in;
            if (wr_beat) begin
              wr_off_reg  <= wr_off_reg + OW'(1);
              wr_addr_reg <= wr_addr_reg + ADDR_WIDTH'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_reg <= RD_IDLE;
      rd_en_reg    <= DEASSERT_L;
      rd_off_reg   <= '0;
      rd_slot_reg  <= '0;
      rd_base_reg  <= BASE0;
      rd_addr_reg  <= BASE0;
    end else begin
      case (rd_state_reg)
        RD_IDLE: begin
          if ((rd_en_in == ASSERT_L) && (frm_cnt_reg != '0)) begin
            rd_state_reg <= RD_READ;
            rd_en_reg    <= ASSERT_L;
          end
        end
        default: begin
          if (rd_last) begin
            rd_state_reg <= RD_IDLE;
            rd_en_reg    <= DEASSERT_L;
            rd_off_reg   <= '0;
            if (rd_release) begin
              rd_slot_reg <= (rd_slot_reg == LAST_SLOT) ? '0 : rd_slot_reg + SW'(1);
              rd_base_reg <= rd_base_next;
              rd_addr_reg <= rd_base_next;
            end else begin
              rd_addr_reg <= rd_base_reg;
            end
          end else begin
            rd_en_reg <= rd_en_in;
            if (rd_beat) begin
              rd_off_reg  <= rd_off_reg + OW'(1);
              rd_addr_reg <= rd_addr_reg + ADDR_WIDTH'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frm_cnt_reg <= '0;
      wr_full_reg <= DEASSERT_H;
    end else begin
      frm_cnt_reg <= frm_cnt_next;
      wr_full_reg <= (frm_cnt_next == CW'(NUM_FRAMES)) ? ASSERT_H : DEASSERT_H;
    end
  end

  assign wr_en   = wr_en_reg;
  assign rd_en   = rd_en_reg;
  assign wr_addr = wr_addr_reg;
  assign rd_addr = rd_addr_reg;
  assign wr_full = wr_full_reg;
  assign frm_cnt = frm_cnt_reg;

endmodule

// File: rtl/frame_buf_multi.sv
// Multi-channel frame buffer address controller: one independent channel
// instance per video stream, ports packed channel-major.
module frame_buf_multi
  import frame_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = 29,
  parameter int BASE_ADDR  = 2,
  parameter int BUF_SIZE   = 230400,
  parameter int NUM_CH     = 2,
  parameter int NUM_FRAMES = 3,
  parameter int RD_REPEAT  = 0,
  localparam int CW        = clog2(NUM_FRAMES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            wr_en_in,
  input  logic [NUM_CH-1:0]            rd_en_in,
  input  logic [NUM_CH-1:0]            wr_rdy,
  input  logic [NUM_CH-1:0]            rd_rdy,
  output logic [NUM_CH-1:0]            wr_en,
  output logic [NUM_CH-1:0]            rd_en,
  output logic [NUM_CH*ADDR_WIDTH-1:0] wr_addr,
  output logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_CH-1:0]            wr_full,
  output logic [NUM_CH*CW-1:0]         frm_cnt
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    frame_buf_chan #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BASE_ADDR  (BASE_ADDR),
      .BUF_SIZE   (BUF_SIZE),
      .NUM_FRAMES (NUM_FRAMES),
      .RD_REPEAT  (RD_REPEAT),
      .CH         (gi),
      .CW         (CW)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .wr_en_in (wr_en_in[gi]),
      .rd_en_in (rd_en_in[gi]),
      .wr_rdy   (wr_rdy[gi]),
      .rd_rdy   (rd_rdy[gi]),
      .wr_en    (wr_en[gi]),
      .rd_en    (rd_en[gi]),
      .wr_addr  (wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]),
      .rd_addr  (rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]),
      .wr_full  (wr_full[gi]),
      .frm_cnt  (frm_cnt[gi*CW +: CW])
    );
  end

endmodule

// File: tb/tb_frame_buf_multi.sv
// Bench for frame_buf_multi: directed steps on a non-repeating and a repeating
// instance, then randomized traffic checked against a frame-level model.
module tb_frame_buf_multi;

  localparam int AW   = 29;
  localparam int BASE = 2;
  localparam int BS   = 4;
  localparam int NCH  = 2;
  localparam int NF   = 3;
  localparam int CW   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NCH-1:0]    wr_en_in_v [2];
  logic [NCH-1:0]    rd_en_in_v [2];
  logic [NCH-1:0]    wr_rdy_v   [2];
  logic [NCH-1:0]    rd_rdy_v   [2];
  logic [NCH-1:0]    wr_en_v    [2];
  logic [NCH-1:0]    rd_en_v    [2];
  logic [NCH-1:0]    wr_full_v  [2];
  logic [NCH*AW-1:0] wr_addr_v  [2];
  logic [NCH*AW-1:0] rd_addr_v  [2];
  logic [NCH*CW-1:0] frm_cnt_v  [2];

  int checks = 0;
  int errors = 0;

  frame_buf_multi #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .BUF_SIZE(BS),
    .NUM_CH(NCH), .NUM_FRAMES(NF), .RD_REPEAT(0)
  ) dut0 (
    .clk(clk), .reset(reset),
    .wr_en_in(wr_en_in_v[0]), .rd_en_in(rd_en_in_v[0]),
    .wr_rdy(wr_rdy_v[0]), .rd_rdy(rd_rdy_v[0]),
    .wr_en(wr_en_v[0]), .rd_en(rd_en_v[0]),
    .wr_addr(wr_addr_v[0]), .rd_addr(rd_addr_v[0]),
    .wr_full(wr_full_v[0]), .frm_cnt(frm_cnt_v[0])
  );

  frame_buf_multi #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .BUF_SIZE(BS),
    .NUM_CH(NCH), .NUM_FRAMES(NF), .RD_REPEAT(1)
  ) dut1 (
    .clk(clk), .reset(reset),
    .wr_en_in(wr_en_in_v[1]), .rd_en_in(rd_en_in_v[1]),
    .wr_rdy(wr_rdy_v[1]), .rd_rdy(rd_rdy_v[1]),
    .wr_en(wr_en_v[1]), .rd_en(rd_en_v[1]),
    .wr_addr(wr_addr_v[1]), .rd_addr(rd_addr_v[1]),
    .wr_full(wr_full_v[1]), .frm_cnt(frm_cnt_v[1])
  );

  function automatic logic [63:0] base_of(input int c, input int s);
    return 64'(BASE + (c * NF + s) * BS);
  endfunction

  function automatic logic [63:0] wa(input int d, input int c);
    return 64'(wr_addr_v[d][c*AW +: AW]);
  endfunction

  function automatic logic [63:0] ra(input int d, input int c);
    return 64'(rd_addr_v[d][c*AW +: AW]);
  endfunction

  function automatic logic [63:0] fc(input int d, input int c);
    return 64'(frm_cnt_v[d][c*CW +: CW]);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      wr_en_in_v[d] = '1;
      rd_en_in_v[d] = '1;
      wr_rdy_v[d]   = '1;
      rd_rdy_v[d]   = '1;
    end
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("%s_wr_addr_d%0d_c%0d", tag, d, c), wa(d, c), base_of(c, 0));
        chk($sformatf("%s_rd_addr_d%0d_c%0d", tag, d, c), ra(d, c), base_of(c, 0));
        chk($sformatf("%s_wr_en_d%0d_c%0d", tag, d, c), 64'(wr_en_v[d][c]), 1);
        chk($sformatf("%s_rd_en_d%0d_c%0d", tag, d, c), 64'(rd_en_v[d][c]), 1);
        chk($sformatf("%s_frm_cnt_d%0d_c%0d", tag, d, c), fc(d, c), 0);
        chk($sformatf("%s_wr_full_d%0d_c%0d", tag, d, c), 64'(wr_full_v[d][c]), 0);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_en(input int d, input int c, input bit is_rd);
    int n = 0;
    step();
    while (((is_rd ? rd_en_v[d][c] : wr_en_v[d][c]) !== 1'b0) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL en_timeout d=%0d ch=%0d rd=%0d observed=deasserted expected=asserted", d, c, is_rd);
    end
  endtask

  task automatic write_frame(input int d, input int c, input int first, input int next, input int cnt);
    wr_en_in_v[d][c] = 1'b0;
    for (int k = 0; k < BS; k++) begin
      wait_en(d, c, 1'b0);
      chk($sformatf("wr_beat_addr_d%0d_k%0d", d, k), wa(d, c), 64'(first + k));
    end
    wr_en_in_v[d][c] = 1'b1;
    step();
    chk("wr_done_en", 64'(wr_en_v[d][c]), 1);
    chk("wr_done_addr", wa(d, c), 64'(next));
    chk("wr_done_cnt", fc(d, c), 64'(cnt));
  endtask

  task automatic read_frame(input int d, input int c, input int first, input int next, input int cnt);
    rd_en_in_v[d][c] = 1'b0;
    for (int k = 0; k < BS; k++) begin
      wait_en(d, c, 1'b1);
      chk($sformatf("rd_beat_addr_d%0d_k%0d", d, k), ra(d, c), 64'(first + k));
    end
    rd_en_in_v[d][c] = 1'b1;
    step();
    chk("rd_done_en", 64'(rd_en_v[d][c]), 1);
    chk("rd_done_addr", ra(d, c), 64'(next));
    chk("rd_done_cnt", fc(d, c), 64'(cnt));
  endtask

  // Writer and reader start together and finish on the same edge.
  task automatic both_frame(input int d, input int c, input int wfirst, input int rfirst,
                            input int wnext, input int rnext, input int cnt);
    wr_en_in_v[d][c] = 1'b0;
    rd_en_in_v[d][c] = 1'b0;
    for (int k = 0; k < BS; k++) begin
      step();
      chk("both_wr_en", 64'(wr_en_v[d][c]), 0);
      chk("both_rd_en", 64'(rd_en_v[d][c]), 0);
      chk("both_wr_addr", wa(d, c), 64'(wfirst + k));
      chk("both_rd_addr", ra(d, c), 64'(rfirst + k));
      chk("both_cnt_mid", fc(d, c), 64'(cnt));
    end
    wr_en_in_v[d][c] = 1'b1;
    rd_en_in_v[d][c] = 1'b1;
    step();
    chk("both_done_wr_en", 64'(wr_en_v[d][c]), 1);
    chk("both_done_rd_en", 64'(rd_en_v[d][c]), 1);
    chk("both_done_wr_addr", wa(d, c), 64'(wnext));
    chk("both_done_rd_addr", ra(d, c), 64'(rnext));
    chk("both_done_cnt", fc(d, c), 64'(cnt));
  endtask

  int ws [NCH];
  int wo [NCH];
  int rs [NCH];
  int ro [NCH];
  int cnt [NCH];
  logic prev_w [NCH];
  logic prev_r [NCH];
  int frames_done;

  initial begin
    // Reset values on both instances
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    check_reset("rst_hold");
    reset = 1'b0;
    step();
    check_reset("rst_rel");

    // Single frame on ch0; ch1 untouched
    write_frame(0, 0, 2, 6, 1);
    $display("single write ch0 done, frm_cnt=%0d wr_addr=%0d", fc(0, 0), wa(0, 0));
    chk("ch1_wr_addr", wa(0, 1), 14);
    chk("ch1_rd_addr", ra(0, 1), 14);
    chk("ch1_wr_en", 64'(wr_en_v[0][1]), 1);
    chk("ch1_cnt", fc(0, 1), 0);

    // Fill the ring, then the writer must stall until a read frees a slot
    write_frame(0, 0, 6, 10, 2);
    write_frame(0, 0, 10, 2, 3);
    chk("full_ch0", 64'(wr_full_v[0][0]), 1);
    chk("full_ch1", 64'(wr_full_v[0][1]), 0);
    wr_en_in_v[0][0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("full_stall_wr_en", 64'(wr_en_v[0][0]), 1);
    end
    read_frame(0, 0, 2, 6, 2);
    chk("after_read_full", 64'(wr_full_v[0][0]), 0);
    chk("after_read_wr_en", 64'(wr_en_v[0][0]), 1);
    write_frame(0, 0, 2, 6, 3);
    $display("full/drain sequence done, frm_cnt=%0d", fc(0, 0));

    // wr_rdy stall at address 4
    do_reset();
    wr_en_in_v[0][0] = 1'b0;
    wait_en(0, 0, 1'b0);
    chk("stall_a0", wa(0, 0), 2);
    step();
    chk("stall_a1", wa(0, 0), 3);
    step();
    chk("stall_a2", wa(0, 0), 4);
    wr_rdy_v[0][0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_addr", wa(0, 0), 4);
      chk("stall_hold_en", 64'(wr_en_v[0][0]), 0);
    end
    wr_rdy_v[0][0] = 1'b1;
    step();
    chk("stall_a3", wa(0, 0), 5);
    wr_en_in_v[0][0] = 1'b1;
    step();
    chk("stall_done_en", 64'(wr_en_v[0][0]), 1);
    chk("stall_done_addr", wa(0, 0), 6);
    chk("stall_done_cnt", fc(0, 0), 1);
    $display("wr_rdy stall frame done, wr_addr=%0d", wa(0, 0));

    // Same-edge write completion and read release
    both_frame(0, 0, 6, 2, 10, 6, 1);
    $display("concurrent write/read done, frm_cnt=%0d", fc(0, 0));

    // Reset in the middle of a frame at offset 2
    wr_en_in_v[0][0] = 1'b0;
    wait_en(0, 0, 1'b0);
    chk("midrst_a0", wa(0, 0), 10);
    step();
    step();
    chk("midrst_a2", wa(0, 0), 12);
    reset = 1'b1;
    wr_en_in_v[0][0] = 1'b1;
    step();
    check_reset("midrst_hold");
    reset = 1'b0;
    step();
    check_reset("midrst_rel");

    // Repeat-read instance
    write_frame(1, 0, 2, 6, 1);
    read_frame(1, 0, 2, 2, 1);
    both_frame(1, 0, 6, 2, 10, 6, 1);
    $display("repeat-read sequence done, rd_addr=%0d frm_cnt=%0d", ra(1, 0), fc(1, 0));

    // Randomized traffic on the non-repeating instance against a frame-level model
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      ws[c] = 0; wo[c] = 0; rs[c] = 0; ro[c] = 0; cnt[c] = 0;
      prev_w[c] = 1'b1; prev_r[c] = 1'b1;
    end
    frames_done = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        chk("rnd_wr_addr", wa(0, c), base_of(c, ws[c]) + 64'(wo[c]));
        chk("rnd_rd_addr", ra(0, c), base_of(c, rs[c]) + 64'(ro[c]));
        chk("rnd_cnt", fc(0, c), 64'(cnt[c]));
        chk("rnd_full", 64'(wr_full_v[0][c]), 64'(cnt[c] == NF));
        if (wr_en_v[0][c] === 1'b0) begin
          chk("rnd_wr_follows_req", 64'(prev_w[c]), 0);
          chk("rnd_wr_has_room", 64'(cnt[c] < NF), 1);
        end
        if (rd_en_v[0][c] === 1'b0) begin
          chk("rnd_rd_follows_req", 64'(prev_r[c]), 0);
          chk("rnd_rd_has_frame", 64'(cnt[c] >= 1), 1);
        end
      end
      for (int c = 0; c < NCH; c++) begin
        wr_en_in_v[0][c] = ($urandom_range(3) == 0);
        rd_en_in_v[0][c] = ($urandom_range(3) == 0);
        wr_rdy_v[0][c]   = ($urandom_range(3) != 0);
        rd_rdy_v[0][c]   = ($urandom_range(3) != 0);
        prev_w[c] = wr_en_in_v[0][c];
        prev_r[c] = rd_en_in_v[0][c];
        if (wr_en_v[0][c] === 1'b0 && wr_rdy_v[0][c]) begin
          wo[c]++;
          if (wo[c] == BS) begin
            wo[c] = 0;
            ws[c] = (ws[c] + 1) % NF;
            cnt[c]++;
            frames_done++;
          end
        end
        if (rd_en_v[0][c] === 1'b0 && rd_rdy_v[0][c]) begin
          ro[c]++;
          if (ro[c] == BS) begin
            ro[c] = 0;
            rs[c] = (rs[c] + 1) % NF;
            cnt[c]--;
          end
        end
      end
      step();
    end
    chk("rnd_progress", 64'(frames_done > 10), 1);
    $display("random phase done, frames written=%0d", frames_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_buf_multi.md
# frame_buf_multi

Multi-channel, multi-slot frame buffer address controller for the Cyclone V GX Starter Kit memory interface. It serves NUM_CH independent video channels, two for the stereo camera pair. Each channel owns a ring of NUM_FRAMES frame slots in external memory. The block generates write and read enables and word addresses, tracks complete frames per channel, and can keep re-reading the last frame so the display path never starves.

## Interface
- ADDR_WIDTH, 29, memory word address width
- BASE_ADDR, 2, first word of channel 0 slot 0
- BUF_SIZE, 230400, words per frame; frame occupies offsets 0..BUF_SIZE-1
- NUM_CH, 2, channel count (≥1)
- NUM_FRAMES, 3, slots per channel (≥2; ≥3 when RD_REPEAT=1)
- RD_REPEAT, 0, 1 = reader re-reads newest complete frame when no newer frame exists
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- wr_en_in  in  NUM_CH  per-channel write request, active-low
- rd_en_in  in  NUM_CH  per-channel read request, active-low
- wr_rdy  in  NUM_CH  memory accepted write beat, active-high
- rd_rdy  in  NUM_CH  memory accepted read beat, active-high
- wr_en  out  NUM_CH  write enable to memory, active-low, registered
- rd_en  out  NUM_CH  read enable to memory, active-low, registered
- wr_addr  out  NUM_CH*ADDR_WIDTH  channel c in bits [c*ADDR_WIDTH +: ADDR_WIDTH]
- rd_addr  out  NUM_CH*ADDR_WIDTH  same packing
- wr_full  out  NUM_CH  all slots hold unread complete frames
- frm_cnt  out  NUM_CH*CW  complete-frame count per channel, CW = clog2(NUM_FRAMES+1)

## Operation
- Slot base for (c,s) = BASE_ADDR + (c*NUM_FRAMES + s)*BUF_SIZE. It is held in registers and advanced by adding BUF_SIZE; at slot NUM_FRAMES-1 it wraps to the channel's slot-0 base. No runtime multiplier.
- Address = slot base + offset. The offset counter is clog2(BUF_SIZE) bits wide.
- Write beat: wr_en[c] asserted and wr_rdy[c]=1 in the same cycle. Read beat: the same rule with rd_en/rd_rdy. Offset increments only on a beat.
- Writer FSM per channel, IDLE / FILL:
  - IDLE→FILL when wr_en_in asserted and frm_cnt < NUM_FRAMES. Otherwise wr_en stays deasserted (stall; no data is dropped by this block).
  - In FILL, wr_en follows the sampled wr_en_in.
  - A beat at offset BUF_SIZE-1 completes the frame: offset←0, slot advances, frm_cnt+1, go to IDLE, wr_en deasserted.
- Reader FSM per channel, IDLE / READ:
  - IDLE→READ when rd_en_in asserted and frm_cnt ≥ 1.
  - In READ, rd_en follows the sampled rd_en_in.
  - A beat at offset BUF_SIZE-1 completes the read:
    - RD_REPEAT=0: slot advances, frm_cnt−1.
    - RD_REPEAT=1: slot advances and frm_cnt−1 only if frm_cnt (including a same-cycle write completion) ≥ 2. Otherwise the slot is kept, frm_cnt is unchanged, and the same frame is read again.
- A write completion and a read release in the same cycle leave frm_cnt unchanged.
- wr_full = (frm_cnt == NUM_FRAMES).
- Channels are fully independent; there is no cross-channel arbitration.

## Timing
- Reset values:
  - wr_en = rd_en = 1 (deasserted); all FSMs IDLE.
  - wr_addr and rd_addr = each channel's slot-0 base.
  - frm_cnt = 0; wr_full = 0.
- All outputs are registered. wr_en/rd_en assert one cycle after the qualifying request is sampled.
- Address is stable while a beat is pending. A beat advances the address on the next edge.
- Write completion is visible in frm_cnt one cycle later. The first rd_en of that frame follows at the earliest two cycles after the completing write beat.
- Reset mid-frame abandons the partial frame; no completion is counted.

## Structure
- Package frame_buf_pkg holds:
  - ASSERT_L/DEASSERT_L and ASSERT_H/DEASSERT_H constants
  - writer/reader state encodings
  - a constant function for the slot base address
  - a clog2 helper
- Sub-module frame_buf_chan implements one channel: both FSMs, slot bases, offsets and frm_cnt. The top level instantiates NUM_CH copies in a generate loop and packs the ports.

## Test plan
Bench parameters: BUF_SIZE=4, NUM_FRAMES=3, NUM_CH=2, BASE_ADDR=2, rdy tied high unless stated.
- Reset → wr_addr ch0=2, ch1=14; rd_addr ch0=2, ch1=14; all enables deasserted; frm_cnt=0.
- ch0 wr_en_in held low → write addresses 2,3,4,5, then wr_en deasserts, frm_cnt[0]=1, wr_addr=6. ch1 outputs unchanged.
- Three frames written with no reads → wr_full[0]=1, wr_en stays deasserted while wr_en_in is low. One full read of addresses 2..5 → frm_cnt=2, writer resumes at address 2.
- wr_rdy dropped low for 3 cycles mid-frame at address 4 → wr_addr holds 4; frame still completes after exactly 4 beats.
- RD_REPEAT=1, one frame written → two consecutive reads both cover 2..5, frm_cnt stays 1. A second frame is written during the second read → that read ends with rd_addr=6 and frm_cnt=1.
- Write completion and read release in the same cycle → frm_cnt unchanged. Reset asserted mid-write at offset 2 → all reset values restored and frm_cnt=0.
